// File: rtl/vga_fb_pixel_writer.sv
// Pixel write front end: turns (x, y, color, meta) requests into single-beat
// AXI writes into a linear frame buffer, one transaction in flight at a time.
module vga_fb_pixel_writer #(
    parameter int H_VISIBLE      = 640,
    parameter int V_VISIBLE      = 480,
    parameter int PIXEL_BITS     = 12,
    parameter int META_BITS      = 4,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(H_VISIBLE)-1:0]  wr_x,
    input  logic [$clog2(V_VISIBLE)-1:0]  wr_y,
    input  logic [PIXEL_BITS-1:0]         wr_color,
    input  logic [META_BITS-1:0]          wr_meta,
    output logic                          busy,
    output logic [7:0]                    drop_count,
    output logic [7:0]                    err_count,
    output logic [AXI_ADDR_WIDTH-1:0]     sram_axi_awaddr,
    output logic                          sram_axi_awvalid,
    input  logic                          sram_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     sram_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   sram_axi_wstrb,
    output logic                          sram_axi_wvalid,
    input  logic                          sram_axi_wready,
    input  logic [1:0]                    sram_axi_bresp,
    input  logic                          sram_axi_bvalid,
    output logic                          sram_axi_bready
);

    localparam int X_W = $clog2(H_VISIBLE);
    localparam int Y_W = $clog2(V_VISIBLE);
    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_VISIBLE);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_VISIBLE);
    localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(H_VISIBLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   aw_done, w_done;
    logic   accept, in_range, aw_hs, w_hs, b_hs;
    logic [AXI_ADDR_WIDTH-1:0] pix_addr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign wr_ready        = (state == IDLE);
    assign busy            = (state != IDLE);
    assign sram_axi_bready = (state == RESP);
    assign sram_axi_wstrb  = '1;

    assign accept   = wr_valid & wr_ready;
    assign in_range = ({1'b0, wr_x} < H_LIM) && ({1'b0, wr_y} < V_LIM);
    assign aw_hs    = sram_axi_awvalid & sram_axi_awready;
    assign w_hs     = sram_axi_wvalid & sram_axi_wready;
    assign b_hs     = sram_axi_bvalid & sram_axi_bready;
    assign pix_addr = STRIDE * AXI_ADDR_WIDTH'(wr_y) + AXI_ADDR_WIDTH'(wr_x);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // RESP is entered on the edge that completes the later of the two handshakes
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && in_range) state_next = WRITE;
            WRITE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = RESP;
            RESP:    if (b_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sram_axi_awvalid <= 1'b0;
            sram_axi_wvalid  <= 1'b0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            sram_axi_awaddr  <= '0;
            sram_axi_wdata   <= '0;
            drop_count       <= 8'd0;
            err_count        <= 8'd0;
        end else begin
            if (accept) begin
                if (in_range) begin
                    sram_axi_awvalid <= 1'b1;
                    sram_axi_wvalid  <= 1'b1;
                    aw_done          <= 1'b0;
                    w_done           <= 1'b0;
                    sram_axi_awaddr  <= pix_addr;
                    sram_axi_wdata   <= {wr_color, wr_meta};
                end else begin
                    drop_count <= sat_inc(drop_count);
                end
            end
            if (aw_hs) begin
                sram_axi_awvalid <= 1'b0;
                aw_done          <= 1'b1;
            end
            if (w_hs) begin
                sram_axi_wvalid <= 1'b0;
                w_done          <= 1'b1;
            end
            if (b_hs && (sram_axi_bresp != 2'b00))
                err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_vga_fb_pixel_writer.sv
// Randomised bench for vga_fb_pixel_writer: a transaction-level model is
// compared against the DUT every cycle, with directed scenarios pinning it.
module tb_vga_fb_pixel_writer;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [11:0]   wr_color;
    logic [3:0]    wr_meta;
    logic          busy;
    logic [7:0]    drop_count, err_count;
    logic [19:0]   sram_axi_awaddr;
    logic          sram_axi_awvalid, sram_axi_awready;
    logic [15:0]   sram_axi_wdata;
    logic [1:0]    sram_axi_wstrb;
    logic          sram_axi_wvalid, sram_axi_wready;
    logic [1:0]    sram_axi_bresp;
    logic          sram_axi_bvalid, sram_axi_bready;

    vga_fb_pixel_writer dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .wr_meta(wr_meta), .busy(busy),
        .drop_count(drop_count), .err_count(err_count),
        .sram_axi_awaddr(sram_axi_awaddr), .sram_axi_awvalid(sram_axi_awvalid),
        .sram_axi_awready(sram_axi_awready), .sram_axi_wdata(sram_axi_wdata),
        .sram_axi_wstrb(sram_axi_wstrb), .sram_axi_wvalid(sram_axi_wvalid),
        .sram_axi_wready(sram_axi_wready), .sram_axi_bresp(sram_axi_bresp),
        .sram_axi_bvalid(sram_axi_bvalid), .sram_axi_bready(sram_axi_bready)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    // Model: which channels are still owed a handshake, plus counters
    bit          m_aw, m_w, m_b;
    logic [19:0] m_addr;
    logic [15:0] m_data;
    int          m_drop, m_err;
    logic [19:0] q_addr[$];
    logic [15:0] q_data[$];
    int          n_aw = 0, n_w = 0, n_b = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expire(input string nm);
        vec++;
        bad++;
        $display("FAIL %s: cycle budget expired, got timeout, expected completion", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave(input logic aw, input logic w, input logic bv, input logic [1:0] br);
        sram_axi_awready = aw;
        sram_axi_wready  = w;
        sram_axi_bvalid  = bv;
        sram_axi_bresp   = br;
    endtask

    task automatic slave_rand();
        slave(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 2'($urandom % 4));
    endtask

    task automatic request(input int x, input int y, input logic [11:0] c, input logic [3:0] m);
        wr_valid = 1'b1;
        wr_x     = XW'(x);
        wr_y     = YW'(y);
        wr_color = c;
        wr_meta  = m;
    endtask

    task automatic monitor();
        bit m_idle, nx_aw, nx_w, nx_b;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_aw = 0; m_w = 0; m_b = 0;
                m_addr = '0; m_data = '0; m_drop = 0; m_err = 0;
                q_addr.delete();
                q_data.delete();
            end else begin
                m_idle = !(m_aw || m_w || m_b);
                check("wr_ready", 32'(wr_ready), 32'(m_idle));
                check("busy", 32'(busy), 32'(!m_idle));
                check("awvalid", 32'(sram_axi_awvalid), 32'(m_aw));
                check("wvalid", 32'(sram_axi_wvalid), 32'(m_w));
                check("bready", 32'(sram_axi_bready), 32'(m_b));
                check("awaddr", 32'(sram_axi_awaddr), 32'(m_addr));
                check("wdata", 32'(sram_axi_wdata), 32'(m_data));
                check("wstrb", 32'(sram_axi_wstrb), 32'h3);
                check("drop_count", 32'(drop_count), 32'(m_drop));
                check("err_count", 32'(err_count), 32'(m_err));
                if (sram_axi_awvalid && sram_axi_awready) begin
                    n_aw++;
                    if (q_addr.size() == 0) check("aw_order_empty", 32'(sram_axi_awaddr), 32'hFFFFFFFF);
                    else check("aw_order", 32'(sram_axi_awaddr), 32'(q_addr.pop_front()));
                end
                if (sram_axi_wvalid && sram_axi_wready) begin
                    n_w++;
                    if (q_data.size() == 0) check("w_order_empty", 32'(sram_axi_wdata), 32'hFFFFFFFF);
                    else check("w_order", 32'(sram_axi_wdata), 32'(q_data.pop_front()));
                end
                if (sram_axi_bvalid && sram_axi_bready) n_b++;
                nx_aw = m_aw && !sram_axi_awready;
                nx_w  = m_w && !sram_axi_wready;
                nx_b  = m_b ? !sram_axi_bvalid : ((m_aw || m_w) && !nx_aw && !nx_w);
                if (m_b && sram_axi_bvalid && sram_axi_bresp != 2'b00 && m_err < 255) m_err++;
                if (m_idle && wr_valid) begin
                    if (int'(wr_x) < H && int'(wr_y) < V) begin
                        nx_aw  = 1;
                        nx_w   = 1;
                        m_addr = 20'(H * int'(wr_y) + int'(wr_x));
                        m_data = {wr_color, wr_meta};
                        q_addr.push_back(m_addr);
                        q_data.push_back(m_data);
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end
                m_aw = nx_aw;
                m_w  = nx_w;
                m_b  = nx_b;
            end
        end
    endtask

    task automatic drain(input string nm);
        int cyc;
        wr_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            slave_rand();
            step();
            cyc++;
        end
        if (busy) expire(nm);
    endtask

    initial begin
        int n, cyc, idx, aw0, w0, b0, hi;
        bit acc;
        int xs[4], ys[4];

        reset = 1'b0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0; wr_meta = '0;
        slave(1'b0, 1'b0, 1'b0, 2'b00);
        fork monitor(); join_none

        step(); step();
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        check("rst_awvalid", 32'(sram_axi_awvalid), 32'h0);
        check("rst_wvalid", 32'(sram_axi_wvalid), 32'h0);
        check("rst_bready", 32'(sram_axi_bready), 32'h0);
        check("rst_awaddr", 32'(sram_axi_awaddr), 32'h0);
        check("rst_wdata", 32'(sram_axi_wdata), 32'h0);
        reset = 1'b1;
        step();

        // Out-of-range requests are swallowed
        slave(1'b1, 1'b1, 1'b1, 2'b00);
        request(640, 0, 12'h123, 4'h1);
        step();
        check("drop_awvalid_a", 32'(sram_axi_awvalid), 32'h0);
        request(0, 480, 12'h456, 4'h2);
        step();
        wr_valid = 1'b0;
        check("drop_awvalid_b", 32'(sram_axi_awvalid), 32'h0);
        check("drop_ready", 32'(wr_ready), 32'h1);
        check("drop_count_2", 32'(drop_count), 32'd2);
        step();

        // Zero-wait single write
        request(5, 2, 12'hF0A, 4'h3);
        step();
        wr_valid = 1'b0;
        check("zw_awaddr", 32'(sram_axi_awaddr), 32'h505);
        check("zw_wdata", 32'(sram_axi_wdata), 32'hF0A3);
        check("zw_wstrb", 32'(sram_axi_wstrb), 32'h3);
        check("zw_busy1", 32'(busy), 32'h1);
        check("zw_ready1", 32'(wr_ready), 32'h0);
        step();
        check("zw_busy2", 32'(busy), 32'h1);
        check("zw_bready", 32'(sram_axi_bready), 32'h1);
        step();
        check("zw_ready3", 32'(wr_ready), 32'h1);
        check("zw_busy3", 32'(busy), 32'h0);

        // AW delayed four cycles, W immediate
        slave(1'b0, 1'b1, 1'b1, 2'b00);
        request(1, 1, 12'hABC, 4'h5);
        step();
        wr_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (sram_axi_awvalid) hi++;
            check("dly_awaddr", 32'(sram_axi_awaddr), 32'd641);
            check("dly_bready", 32'(sram_axi_bready), 32'h0);
            if (i == 1) check("dly_wvalid_dropped", 32'(sram_axi_wvalid), 32'h0);
            if (i == 3) sram_axi_awready = 1'b1;
            step();
        end
        check("dly_aw_cycles", 32'(hi), 32'd4);
        check("dly_resp", 32'(sram_axi_bready), 32'h1);
        check("dly_awvalid_low", 32'(sram_axi_awvalid), 32'h0);
        step();

        // Error responses saturate
        slave(1'b1, 1'b1, 1'b1, 2'b10);
        n = 0; cyc = 0;
        request(3, 3, 12'h0F0, 4'h0);
        while (n < 300 && cyc < 1200) begin
            if (wr_ready) begin
                n++;
                request(int'($urandom % H), int'($urandom % V), 12'($urandom), 4'($urandom));
            end
            step();
            cyc++;
        end
        wr_valid = 1'b0;
        if (n < 300) expire("err_sat_loop");
        step(); step(); step();
        check("err_sat", 32'(err_count), 32'd255);

        // Reset while a write is stalled
        slave(1'b0, 1'b0, 1'b0, 2'b00);
        request(10, 10, 12'h777, 4'h7);
        step();
        wr_valid = 1'b0;
        check("mid_awvalid_pre", 32'(sram_axi_awvalid), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("mid_awvalid", 32'(sram_axi_awvalid), 32'h0);
        check("mid_wvalid", 32'(sram_axi_wvalid), 32'h0);
        check("mid_ready", 32'(wr_ready), 32'h1);
        check("mid_err", 32'(err_count), 32'h0);
        check("mid_awaddr", 32'(sram_axi_awaddr), 32'h0);
        step();
        reset = 1'b1;
        step();
        check("post_ready", 32'(wr_ready), 32'h1);
        check("post_awvalid", 32'(sram_axi_awvalid), 32'h0);
        slave(1'b1, 1'b1, 1'b1, 2'b00);
        request(639, 479, 12'hFFF, 4'hF);
        step();
        wr_valid = 1'b0;
        check("corner_awaddr", 32'(sram_axi_awaddr), 32'h4AFFF);
        check("corner_wdata", 32'(sram_axi_wdata), 32'hFFFF);
        step(); step();

        // Four back-to-back requests under random stalls
        aw0 = n_aw; w0 = n_w; b0 = n_b;
        for (int i = 0; i < 4; i++) begin
            xs[i] = int'($urandom % H);
            ys[i] = int'($urandom % V);
        end
        idx = 0; cyc = 0;
        request(xs[0], ys[0], 12'($urandom), 4'($urandom));
        while (idx < 4 && cyc < 300) begin
            slave_rand();
            acc = wr_ready;
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) request(xs[idx], ys[idx], 12'($urandom), 4'($urandom));
            end
        end
        if (idx < 4) expire("b2b_accept");
        drain("b2b_drain");
        check("b2b_aw_count", 32'(n_aw - aw0), 32'd4);
        check("b2b_w_count", 32'(n_w - w0), 32'd4);
        check("b2b_b_count", 32'(n_b - b0), 32'd4);

        // Free-running random traffic, including out-of-range coordinates
        for (int i = 0; i < 600; i++) begin
            slave_rand();
            wr_valid = 1'($urandom % 2);
            wr_x     = ($urandom % 8 == 0) ? XW'($urandom) : XW'($urandom % H);
            wr_y     = ($urandom % 8 == 0) ? YW'($urandom) : YW'($urandom % V);
            wr_color = 12'($urandom);
            wr_meta  = 4'($urandom);
            step();
        end
        drain("rand_drain");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
